rcvfifo: RTL and testbench

Parametrised successor to the single-byte serial receive buffer. It combines an asynchronous-serial receiver (start/data/stop framing, runtime bit_len) with a DEPTH-entry FIFO. It also reports sticky overrun and framing-error flags. It sits between the serial_in pin and the CPU I/O register decode; the CPU reads in show-ahead fashion.

---
 rtl/rcvfifo_pkg.sv | 13 +
 rtl/rcvfifo_rcv_shift.sv | 106 ++++++++++
 rtl/rcvfifo.sv | 109 ++++++++++
 tb/tb_rcvfifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rcvfifo_pkg.sv
// Shared types for the serial receive FIFO: receiver state encoding and timer width.
package rcvfifo_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } rx_state_e;

   localparam int unsigned TimerW = 16;

endpackage

// File: rtl/rcvfifo_rcv_shift.sv
// Asynchronous-serial receiver: 2-flop synchroniser, bit timer and framing FSM.
// Emits a one-clock push with the assembled word, or stop_err on a low stop bit.
module rcv_shift
   import rcvfifo_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TimerW-1:0]    bit_len,
   input  logic                 serial_in,
   output logic                 push,
   output logic [DATA_BITS-1:0] word,
   output logic                 stop_err
);

   localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);

   logic                 sync1_q, sync2_q, rx_prev_q;
   logic                 rx_s;
   rx_state_e            state_q, state_d;
   logic [TimerW-1:0]    timer_q, timer_d;
   logic [BitCntW-1:0]   bitcnt_q, bitcnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 timer_zero;

   assign rx_s       = sync2_q;
   assign timer_zero = (timer_q == '0);
   assign word       = shreg_q;

   // Requiring the previous sample high also makes IDLE wait for the line to
   // recover after a low stop bit before arming a new start.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      bitcnt_d = bitcnt_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      stop_err = 1'b0;
      case (state_q)
         StIdle: begin
            if (rx_prev_q && !rx_s) begin
               timer_d = (bit_len >> 1) - TimerW'(1);
               state_d = StStart;
            end
         end
         StStart: begin
            if (timer_zero) begin
               if (rx_s) begin
                  state_d = StIdle;
               end else begin
                  timer_d  = bit_len - TimerW'(1);
                  bitcnt_d = '0;
                  state_d  = StData;
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StData: begin
            if (timer_zero) begin
               shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
               timer_d = bit_len - TimerW'(1);
               if (bitcnt_q == BitCntW'(DATA_BITS - 1)) begin
                  state_d = StStop;
               end else begin
                  bitcnt_d = bitcnt_q + BitCntW'(1);
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StStop: begin
            if (timer_zero) begin
               push     = rx_s;
               stop_err = !rx_s;
               state_d  = StIdle;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= StIdle;
         timer_q   <= '0;
         bitcnt_q  <= '0;
         shreg_q   <= '0;
      end else begin
         sync1_q   <= serial_in;
         sync2_q   <= sync1_q;
         rx_prev_q <= sync2_q;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bitcnt_q  <= bitcnt_d;
         shreg_q   <= shreg_d;
      end
   end

endmodule

// File: rtl/rcvfifo.sv
// Serial receiver feeding a DEPTH-entry show-ahead FIFO, with sticky overrun
// and framing-error flags for the CPU register interface.
module rcvfifo
   import rcvfifo_pkg::*;
#(
   parameter  int unsigned DATA_BITS = 8,
   parameter  int unsigned DEPTH     = 16,
   localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TimerW-1:0]    bit_len,
   input  logic                 read,
   input  logic                 clear_err,
   input  logic                 serial_in,
   output logic                 ready,
   output logic [DATA_BITS-1:0] data_out,
   output logic [CNT_W-1:0]     count,
   output logic                 overrun,
   output logic                 frame_err
);

   localparam int unsigned PtrW = $clog2(DEPTH);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("rcvfifo: DATA_BITS must be 5..9");
   end
   if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rcvfifo: DEPTH must be a power of two in 2..256");
   end

   logic                 push, stop_err;
   logic [DATA_BITS-1:0] word;

   logic [DATA_BITS-1:0] mem_q [DEPTH];
   logic [DATA_BITS-1:0] mem_d [DEPTH];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic                 full, pop, wr_en, drop;

   rcv_shift #(
      .DATA_BITS (DATA_BITS)
   ) u_rcv_shift (
      .clk       (clk),
      .rst       (rst),
      .bit_len   (bit_len),
      .serial_in (serial_in),
      .push      (push),
      .word      (word),
      .stop_err  (stop_err)
   );

   assign full  = (count_q == CNT_W'(DEPTH));
   assign ready = (count_q != '0);
   assign pop   = read & ready;
   // When full, a simultaneous pop frees the head slot, which is the one wr_ptr names.
   assign wr_en = push & (~full | pop);
   assign drop  = push & full & ~pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Set wins over a same-cycle clear.
   assign overrun_d   = drop | (overrun_q & ~clear_err);
   assign frame_err_d = stop_err | (frame_err_q & ~clear_err);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign data_out  = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rcvfifo.sv
// Self-checking bench for rcvfifo: directed table, hand-timed corner cases and
// randomized frames/reads/clears against a queue-based reference model.
module tb_rcvfifo;

   localparam int DataBits = 8;
   localparam int Depth    = 4;
   localparam int CntW     = $clog2(Depth + 1);

   logic                clk = 1'b0;
   logic                rst;
   logic [15:0]         bit_len;
   logic                read, clear_err, serial_in;
   logic                ready, overrun, frame_err;
   logic [DataBits-1:0] data_out;
   logic [CntW-1:0]     count;

   int checks = 0;
   int errors = 0;

   rcvfifo #(
      .DATA_BITS (DataBits),
      .DEPTH     (Depth)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bit_len   (bit_len),
      .read      (read),
      .clear_err (clear_err),
      .serial_in (serial_in),
      .ready     (ready),
      .data_out  (data_out),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef enum int {OpFrame, OpBad, OpRead, OpClear} op_e;
   typedef struct {
      op_e         op;
      logic [7:0]  data;
      int          bl;
      int          exp_count;
      logic        exp_ready;
      logic [7:0]  exp_head;
      logic        exp_ovr;
      logic        exp_ferr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int cnt, input logic rdy,
                            input logic [7:0] head, input logic ovr, input logic fe);
      @(negedge clk);
      chk({tag, ".count"}, 32'(count), 32'(cnt));
      chk({tag, ".ready"}, 32'(ready), 32'(rdy));
      chk({tag, ".overrun"}, 32'(overrun), 32'(ovr));
      chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
      if (rdy) chk({tag, ".data_out"}, 32'(data_out), 32'(head));
   endtask

   // Start bit is driven 1 time unit after the first posedge seen by this task.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int bl);
      bit_len = 16'(bl);
      @(posedge clk); #1; serial_in = 1'b0;
      for (int i = 0; i < DataBits; i++) begin
         repeat (bl) @(posedge clk);
         #1; serial_in = d[i];
      end
      repeat (bl) @(posedge clk); #1; serial_in = stop;
      repeat (bl) @(posedge clk); #1; serial_in = 1'b1;
      repeat (2 * bl) @(posedge clk);
   endtask

   task automatic do_read();
      @(posedge clk); #1; read = 1'b1;
      @(posedge clk); #1; read = 1'b0;
   endtask

   task automatic do_clear();
      @(posedge clk); #1; clear_err = 1'b1;
      @(posedge clk); #1; clear_err = 1'b0;
   endtask

   logic [7:0] mq[$];
   logic       movr, mfe;
   logic [7:0] rd;
   int         bl_r, op_r;

   initial begin
      rst = 1'b1; bit_len = 16'd16; read = 1'b0; clear_err = 1'b0; serial_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset.count", 32'(count), 32'd0);
      chk("reset.ready", 32'(ready), 32'd0);
      chk("reset.overrun", 32'(overrun), 32'd0);
      chk("reset.frame_err", 32'(frame_err), 32'd0);
      chk("reset.data_out", 32'(data_out), 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      repeat (4) @(posedge clk);

      // Push lands on edge 3 + bit_len/2 + 9*bit_len after the start-bit edge.
      fork
         send_frame(8'h5A, 1'b1, 16);
         begin
            @(posedge clk);
            repeat (154) @(posedge clk);
            #1 chk("latency.before", 32'(count), 32'd0);
            @(posedge clk);
            #1 chk("latency.count", 32'(count), 32'd1);
            chk("latency.ready", 32'(ready), 32'd1);
            chk("latency.data", 32'(data_out), 32'h5A);
         end
      join
      do_read();
      chk_state("t1.read", 0, 1'b0, 8'h00, 1'b0, 1'b0);

      vecs.push_back('{OpFrame, 8'h01, 8, 1, 1'b1, 8'h01, 1'b0, 1'b0});
      vecs.push_back('{OpFrame, 8'h02, 8, 2, 1'b1, 8'h01, 1'b0, 1'b0});
      vecs.push_back('{OpFrame, 8'h03, 8, 3, 1'b1, 8'h01, 1'b0, 1'b0});
      vecs.push_back('{OpFrame, 8'h04, 8, 4, 1'b1, 8'h01, 1'b0, 1'b0});
      vecs.push_back('{OpFrame, 8'h05, 8, 4, 1'b1, 8'h01, 1'b1, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 3, 1'b1, 8'h02, 1'b1, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 2, 1'b1, 8'h03, 1'b1, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 1, 1'b1, 8'h04, 1'b1, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 0, 1'b0, 8'h00, 1'b1, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 0, 1'b0, 8'h00, 1'b1, 1'b0});
      vecs.push_back('{OpClear, 8'h00, 8, 0, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{OpFrame, 8'h21, 8, 1, 1'b1, 8'h21, 1'b0, 1'b0});
      vecs.push_back('{OpBad,   8'h33, 8, 1, 1'b1, 8'h21, 1'b0, 1'b1});
      vecs.push_back('{OpClear, 8'h00, 8, 1, 1'b1, 8'h21, 1'b0, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 0, 1'b0, 8'h00, 1'b0, 1'b0});
      vecs.push_back('{OpFrame, 8'h44, 12, 1, 1'b1, 8'h44, 1'b0, 1'b0});
      vecs.push_back('{OpRead,  8'h00, 8, 0, 1'b0, 8'h00, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         case (vecs[i].op)
            OpFrame: send_frame(vecs[i].data, 1'b1, vecs[i].bl);
            OpBad:   send_frame(vecs[i].data, 1'b0, vecs[i].bl);
            OpRead:  do_read();
            default: do_clear();
         endcase
         chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ready,
                   vecs[i].exp_head, vecs[i].exp_ovr, vecs[i].exp_ferr);
      end

      // Full FIFO, read coincides with the push of the next word.
      send_frame(8'h11, 1'b1, 8);
      send_frame(8'h12, 1'b1, 8);
      send_frame(8'h13, 1'b1, 8);
      send_frame(8'h14, 1'b1, 8);
      fork
         send_frame(8'h66, 1'b1, 8);
         begin
            @(posedge clk);
            repeat (78) @(posedge clk);
            #1 read = 1'b1;
            @(posedge clk);
            #1 read = 1'b0;
         end
      join
      chk_state("t3.push_pop", 4, 1'b1, 8'h12, 1'b0, 1'b0);
      do_read(); chk_state("t3.r1", 3, 1'b1, 8'h13, 1'b0, 1'b0);
      do_read(); chk_state("t3.r2", 2, 1'b1, 8'h14, 1'b0, 1'b0);
      do_read(); chk_state("t3.r3", 1, 1'b1, 8'h66, 1'b0, 1'b0);
      do_read(); chk_state("t3.r4", 0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Short low glitch on an idle line is a false start.
      bit_len = 16'd16;
      @(posedge clk); #1 serial_in = 1'b0;
      repeat (4) @(posedge clk); #1 serial_in = 1'b1;
      repeat (48) @(posedge clk);
      chk_state("t5.glitch", 0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b1, 16);
      chk_state("t5.after", 1, 1'b1, 8'h3C, 1'b0, 1'b0);
      do_read();

      // Reset in the middle of a data field.
      send_frame(8'h77, 1'b1, 16);
      send_frame(8'h0F, 1'b0, 16);
      chk_state("t6.pre", 1, 1'b1, 8'h77, 1'b0, 1'b1);
      @(posedge clk); #1 serial_in = 1'b0;
      repeat (16) @(posedge clk); #1 serial_in = 1'b1;
      repeat (48) @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("t6.rst.count", 32'(count), 32'd0);
      chk("t6.rst.ready", 32'(ready), 32'd0);
      chk("t6.rst.overrun", 32'(overrun), 32'd0);
      chk("t6.rst.frame_err", 32'(frame_err), 32'd0);
      chk("t6.rst.data_out", 32'(data_out), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (200) @(posedge clk);
      chk_state("t6.quiet", 0, 1'b0, 8'h00, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 16);
      chk_state("t6.after", 1, 1'b1, 8'hA5, 1'b0, 1'b0);
      do_read();
      chk_state("t6.read", 0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Randomized traffic against a queue model.
      movr = 1'b0;
      mfe  = 1'b0;
      for (int n = 0; n < 40; n++) begin
         op_r = int'($urandom_range(0, 9));
         if (op_r <= 5) begin
            bl_r = int'($urandom_range(4, 20));
            rd   = 8'($urandom);
            if ($urandom_range(0, 7) != 0) begin
               send_frame(rd, 1'b1, bl_r);
               if (mq.size() < Depth) mq.push_back(rd);
               else movr = 1'b1;
            end else begin
               send_frame(rd, 1'b0, bl_r);
               mfe = 1'b1;
            end
         end else if (op_r <= 8) begin
            do_read();
            if (mq.size() > 0) void'(mq.pop_front());
         end else begin
            do_clear();
            movr = 1'b0;
            mfe  = 1'b0;
         end
         chk_state($sformatf("rnd%0d", n), mq.size(), mq.size() > 0,
                   (mq.size() > 0) ? mq[0] : 8'h00, movr, mfe);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
